// File: rtl/parity_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : parity_frame_tx
//  Brief    : Serialises a word as start(0), data LSB-first, parity, stop(1).
//  Revision : 1.0 - initial release
// ============================================================================
module parity_frame_tx #(
    parameter int DATA_W       = 3,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_odd,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic              parity_out
);

    localparam int c_bit_cw = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_idx_cw = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_bit_cw-1:0] c_bit_last = c_bit_cw'(CLKS_PER_BIT - 1);
    localparam logic [c_idx_cw-1:0] c_idx_last = c_idx_cw'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_bit_cw-1:0] r_bit_cnt;
    logic [c_bit_cw-1:0] w_bit_cnt_next;
    logic [c_idx_cw-1:0] r_idx;
    logic [c_idx_cw-1:0] w_idx_next;
    logic [DATA_W-1:0]   r_data;
    logic                r_parity;
    logic                r_tx;
    logic                r_busy;
    logic                r_done;
    logic                w_tx_next;
    logic                w_accept;
    logic                w_bit_last;
    logic                w_parity_calc;

    assign in_ready      = (r_state == ST_IDLE) && !rst;
    assign w_accept      = in_valid && in_ready;
    assign w_parity_calc = (^in_data) ^ in_odd;
    assign w_bit_last    = (r_bit_cnt == c_bit_last);

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt + 1'b1;
        w_idx_next     = r_idx;
        w_tx_next      = 1'b1;

        case (r_state)
            ST_IDLE: begin
                w_bit_cnt_next = '0;
                if (w_accept) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_last) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_last) begin
                    if (r_idx == c_idx_last) begin
                        w_state_next = ST_PARITY;
                    end else begin
                        w_idx_next     = r_idx + 1'b1;
                        w_bit_cnt_next = '0;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_last) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Counters restart on every state change so no bit is ever cut short.
        if (w_state_next != r_state) begin
            w_bit_cnt_next = '0;
            w_idx_next     = '0;
        end

        // The line level is registered, so decode it from the upcoming state.
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = r_data[w_idx_next];
            ST_PARITY: w_tx_next = r_parity;
            default:   w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_idx     <= '0;
            r_data    <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_idx     <= w_idx_next;
            r_tx      <= w_tx_next;
            r_busy    <= (w_state_next != ST_IDLE);
            r_done    <= (r_state == ST_STOP) && (w_state_next == ST_IDLE);
            if (w_accept) begin
                r_data   <= in_data;
                r_parity <= w_parity_calc;
            end
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign done       = r_done;
    assign parity_out = r_parity;

endmodule
`default_nettype wire
